// File: rtl/instr_encode_loader.sv
//==============================================================================
// Module      : instr_encode_loader
// Description : Turns a control bundle plus operand fields back into a 16-bit
//               instruction and writes it to IMEM at sequential addresses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_encode_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        reg_dst,
  input  logic [1:0]        mem_to_reg,
  input  logic [1:0]        alu_op,
  input  logic              jump,
  input  logic              branch,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              alu_src,
  input  logic              reg_write,
  input  logic              sign_or_zero,
  input  logic [2:0]        rs,
  input  logic [2:0]        rt,
  input  logic [2:0]        rd,
  input  logic [3:0]        funct,
  input  logic [6:0]        imm,
  input  logic [12:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  input  logic              imem_ack,
  output logic              illegal,
  output logic              full,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  // Bundle order: reg_dst, mem_to_reg, alu_op, jump, branch, mem_read,
  // mem_write, alu_src, reg_write, sign_or_zero
  localparam logic [12:0] C_B_ADD  = 13'b01_00_00_0_0_0_0_0_1_1;
  localparam logic [12:0] C_B_SLI  = 13'b00_00_10_0_0_0_0_1_1_0;
  localparam logic [12:0] C_B_J    = 13'b00_00_00_1_0_0_0_0_0_1;
  localparam logic [12:0] C_B_JAL  = 13'b10_10_00_1_0_0_0_0_1_1;
  localparam logic [12:0] C_B_LW   = 13'b00_01_11_0_0_1_0_1_1_1;
  localparam logic [12:0] C_B_SW   = 13'b00_00_11_0_0_0_1_1_0_1;
  localparam logic [12:0] C_B_BEQ  = 13'b00_00_01_0_1_0_0_0_0_1;
  localparam logic [12:0] C_B_ADDI = 13'b00_00_11_0_0_0_0_1_1_1;

  localparam logic [ADDR_W-1:0] C_BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] C_ONE_A = ADDR_W'(1);
  localparam logic [ADDR_W:0]   C_ONE_C = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W+1)'(DEPTH);
  // When the region ends exactly at the top of the address space the
  // one-past-end address is unrepresentable, so hold at the last word.
  localparam bit C_AT_TOP = (BASE_ADDR + DEPTH) >= (1 << ADDR_W);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic [ADDR_W:0]     r_count;
  logic                r_full;

  logic [12:0]         w_bundle;
  logic [2:0]          w_op;
  logic                w_legal;
  logic [15:0]         w_word;
  logic                w_accept;
  logic                w_done;
  logic [ADDR_W:0]     w_count_nxt;

  assign w_bundle = {reg_dst, mem_to_reg, alu_op, jump, branch, mem_read,
                     mem_write, alu_src, reg_write, sign_or_zero};

  always_comb begin
    w_legal = 1'b1;
    w_op    = 3'b000;
    case (w_bundle)
      C_B_ADD:  w_op = 3'b000;
      C_B_SLI:  w_op = 3'b001;
      C_B_J:    w_op = 3'b010;
      C_B_JAL:  w_op = 3'b011;
      C_B_LW:   w_op = 3'b100;
      C_B_SW:   w_op = 3'b101;
      C_B_BEQ:  w_op = 3'b110;
      C_B_ADDI: w_op = 3'b111;
      default:  w_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (w_op)
      3'b000:         w_word = {w_op, rs, rt, rd, funct};
      3'b010, 3'b011: w_word = {w_op, target};
      default:        w_word = {w_op, rs, rt, imm};
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    imem_we     = 1'b0;
    illegal     = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = ~r_full;
        w_accept = in_valid & ~r_full;
        if (w_accept) w_state_nxt = w_legal ? S_WRITE : S_ERR;
      end
      S_WRITE: begin
        imem_we = 1'b1;
        w_done  = imem_ack;
        if (imem_ack) w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        illegal     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_count_nxt = r_count + C_ONE_C;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= C_BASE;
      r_wdata <= 16'h0000;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && w_legal) r_wdata <= w_word;
      if (w_done) begin
        r_count <= w_count_nxt;
        if (w_count_nxt == C_DEPTH) r_full <= 1'b1;
        if (!(C_AT_TOP && (w_count_nxt == C_DEPTH))) r_addr <= r_addr + C_ONE_A;
      end
    end
  end

  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign full       = r_full;
  assign word_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_encode_loader.sv
//==============================================================================
// Module      : tb_instr_encode_loader
// Description : Scoreboard bench for instr_encode_loader (DEPTH=4, BASE=0).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instr_encode_loader;

  localparam int ADDR_W = 8;

  localparam logic [12:0] B_ADD  = 13'b01_00_00_0_0_0_0_0_1_1;
  localparam logic [12:0] B_SLI  = 13'b00_00_10_0_0_0_0_1_1_0;
  localparam logic [12:0] B_J    = 13'b00_00_00_1_0_0_0_0_0_1;
  localparam logic [12:0] B_JAL  = 13'b10_10_00_1_0_0_0_0_1_1;
  localparam logic [12:0] B_LW   = 13'b00_01_11_0_0_1_0_1_1_1;
  localparam logic [12:0] B_SW   = 13'b00_00_11_0_0_0_1_1_0_1;
  localparam logic [12:0] B_BEQ  = 13'b00_00_01_0_1_0_0_0_0_1;
  localparam logic [12:0] B_ADDI = 13'b00_00_11_0_0_0_0_1_1_1;
  localparam logic [12:0] B_BAD  = 13'b01_00_00_0_0_0_0_0_1_0;

  logic clk, reset, in_valid, in_ready;
  logic [1:0] reg_dst, mem_to_reg, alu_op;
  logic jump, branch, mem_read, mem_write, alu_src, reg_write, sign_or_zero;
  logic [2:0] rs, rt, rd;
  logic [3:0] funct;
  logic [6:0] imm;
  logic [12:0] target;
  logic imem_we, imem_ack, illegal, full;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0] imem_wdata;
  logic [ADDR_W:0] word_count;

  typedef struct packed {
    logic              legal;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int fails = 0;
  int ack_delay = 0;
  logic [ADDR_W-1:0] exp_addr = '0;

  instr_encode_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .jump(jump), .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .sign_or_zero(sign_or_zero),
    .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .target(target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ack(imem_ack), .illegal(illegal), .full(full), .word_count(word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // IMEM responder: acks after ack_delay idle WRITE cycles.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    imem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_we) begin
        if (wait_cnt >= ack_delay) begin
          imem_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops one expectation per completed write or illegal pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (imem_we && imem_ack) begin
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL write_unexpected: addr %0h data %0h, none expected", imem_addr, imem_wdata);
          end else begin
            e = exp_q.pop_front();
            if (!e.legal || e.addr !== imem_addr || e.data !== imem_wdata) begin
              fails++;
              $display("FAIL write: got addr %0h data %0h, expected legal=%0d addr %0h data %0h",
                       imem_addr, imem_wdata, e.legal, e.addr, e.data);
            end
          end
        end
        if (illegal) begin
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL illegal_unexpected: illegal pulse at addr %0h, none expected", imem_addr);
          end else begin
            e = exp_q.pop_front();
            if (e.legal || e.addr !== imem_addr || imem_we) begin
              fails++;
              $display("FAIL illegal: got addr %0h we %0d, expected illegal at addr %0h",
                       imem_addr, imem_we, e.addr);
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [12:0] b, input logic [2:0] s, input logic [2:0] t,
                      input logic [2:0] d, input logic [3:0] f, input logic [6:0] im,
                      input logic [12:0] tg, input bit legal, input logic [15:0] w,
                      input bit push);
    int n;
    exp_t e;
    n = 0;
    @(posedge clk);
    #1;
    {reg_dst, mem_to_reg, alu_op, jump, branch, mem_read, mem_write, alu_src,
     reg_write, sign_or_zero} = b;
    rs = s; rt = t; rd = d; funct = f; imm = im; target = tg;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
    end else if (push) begin
      e.legal = legal; e.addr = exp_addr; e.data = w;
      exp_q.push_back(e);
      if (legal) exp_addr++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0;
    {reg_dst, mem_to_reg, alu_op, jump, branch, mem_read, mem_write, alu_src,
     reg_write, sign_or_zero} = '0;
    rs = '0; rt = '0; rd = '0; funct = '0; imm = '0; target = '0;
    do_reset();
    @(negedge clk);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Test 1: add
    send(B_ADD, 3'd1, 3'd2, 3'd3, 4'h0, 7'h55, 13'h1ABC, 1'b1, 16'h0530, 1'b1);
    drain();
    chk("t1_count", 32'(word_count), 32'd1);

    // Test 2: lw then jal
    send(B_LW, 3'd0, 3'd4, 3'd7, 4'hF, 7'h05, 13'h0F0F, 1'b1, 16'h8205, 1'b1);
    send(B_JAL, 3'd5, 3'd6, 3'd1, 4'h3, 7'h2A, 13'h0123, 1'b1, 16'h6123, 1'b1);
    drain();
    chk("t2_count", 32'(word_count), 32'd3);

    // Test 3: illegal bundle, then sw lands at the same address
    send(B_BAD, 3'd1, 3'd2, 3'd3, 4'h0, 7'h00, 13'h0000, 1'b0, 16'h0000, 1'b1);
    drain();
    chk("t3_addr_after_illegal", 32'(imem_addr), 32'd3);
    chk("t3_count_after_illegal", 32'(word_count), 32'd3);
    send(B_SW, 3'd5, 3'd6, 3'd0, 4'h0, 7'h01, 13'h0000, 1'b1, 16'hB701, 1'b1);
    drain();
    chk("t3_full", 32'(full), 32'd1);

    // Test 4: held ack
    do_reset();
    ack_delay = 5;
    send(B_ADDI, 3'd2, 3'd3, 3'd0, 4'h0, 7'h7F, 13'h0000, 1'b1, 16'hE9FF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_we", 32'(imem_we), 32'd1);
      chk("t4_addr", 32'(imem_addr), 32'd0);
      chk("t4_wdata", 32'(imem_wdata), 32'hE9FF);
      chk("t4_ready", 32'(in_ready), 32'd0);
    end
    ack_delay = 0;
    send(B_BEQ, 3'd1, 3'd1, 3'd0, 4'h0, 7'h10, 13'h0000, 1'b1, 16'hC490, 1'b1);
    drain();
    chk("t4_count", 32'(word_count), 32'd2);

    // Test 5: fill DEPTH=4, fifth held off
    do_reset();
    send(B_J, 3'd0, 3'd0, 3'd0, 4'h0, 7'h33, 13'h1FFF, 1'b1, 16'h5FFF, 1'b1);
    send(B_SLI, 3'd7, 3'd7, 3'd0, 4'h0, 7'h2A, 13'h0000, 1'b1, 16'h3FAA, 1'b1);
    send(B_ADD, 3'd7, 3'd0, 3'd5, 4'hF, 7'h00, 13'h0000, 1'b1, 16'h1C5F, 1'b1);
    chk("t5_not_full_yet", 32'(full), 32'd0);
    send(B_LW, 3'd3, 3'd1, 3'd0, 4'h0, 7'h40, 13'h0000, 1'b1, 16'h8CC0, 1'b1);
    drain();
    chk("t5_full", 32'(full), 32'd1);
    chk("t5_count", 32'(word_count), 32'd4);
    chk("t5_addr", 32'(imem_addr), 32'd4);
    {reg_dst, mem_to_reg, alu_op, jump, branch, mem_read, mem_write, alu_src,
     reg_write, sign_or_zero} = B_ADDI;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_held_ready", 32'(in_ready), 32'd0);
      chk("t5_held_we", 32'(imem_we), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t5_count_held", 32'(word_count), 32'd4);

    // Test 6: reset during a pending write
    do_reset();
    chk("t6_full_cleared", 32'(full), 32'd0);
    send(B_SW, 3'd5, 3'd6, 3'd0, 4'h0, 7'h01, 13'h0000, 1'b1, 16'hB701, 1'b1);
    drain();
    ack_delay = 3;
    send(B_ADDI, 3'd2, 3'd3, 3'd0, 4'h0, 7'h7F, 13'h0000, 1'b1, 16'hE9FF, 1'b0);
    @(negedge clk);
    chk("t6_we_before", 32'(imem_we), 32'd1);
    chk("t6_addr_before", 32'(imem_addr), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_we_async", 32'(imem_we), 32'd0);
    chk("t6_addr_async", 32'(imem_addr), 32'd0);
    chk("t6_count_async", 32'(word_count), 32'd0);
    chk("t6_full_async", 32'(full), 32'd0);
    exp_addr = '0;
    ack_delay = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_write_after", 32'(imem_we), 32'd0);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
